imem_loader: RTL and testbench

//   Writer side of the single-cycle datapath's instruction memory. Accepts a byte stream (valid/ready)

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_word_packer.sv | 42 ++++
 rtl/imem_loader.sv | 150 +++++++++++++++
 tb/tb_imem_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and loader state encoding for the instruction-memory loader.
package imem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_DONE
    } loader_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted stream bytes little-endian into one instruction word.
module imem_word_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (byte_en) begin
            word_d[{cnt_q, 3'b000} +: 8] = byte_in;
            cnt_d                        = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word      = word_q;
    assign word_full = byte_en && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory word writer with range check.
// Optional running checksum of written words: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [WORD_W-1:0] checksum
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;

    logic              start_acc;
    logic              range_err;
    logic [ADDR_W:0]   end_addr;
    logic [WORD_W-1:0] pack_word;
    logic              pack_full;

    assign start_acc = (state_q == ST_IDLE) && start;
    // Extra bit keeps base=DEPTH-1 plus a full count from wrapping.
    assign end_addr  = {1'b0, base_addr} + word_count;
    assign range_err = end_addr > DEPTH_L;

    imem_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_q == ST_IDLE),
        .byte_en   (in_valid && in_ready),
        .byte_in   (in_byte),
        .word      (pack_word),
        .word_full (pack_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !range_err) begin
                    state_d = (word_count == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD:  if (pack_full) state_d = ST_WRITE;
            ST_WRITE: state_d = (rem_q == (ADDR_W+1)'(1)) ? ST_DONE : ST_LOAD;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_LOAD);
        wr_en    = (state_q == ST_WRITE);
        busy     = (state_q == ST_LOAD) || (state_q == ST_WRITE);
        done     = (state_q == ST_DONE);
    end

    always_comb begin
        idx_d     = idx_q;
        rem_d     = rem_q;
        error_d   = error_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (start_acc) begin
            error_d = range_err;
            if (!range_err) begin
                idx_d = base_addr;
                rem_d = word_count;
            end
        end
        if (state_q == ST_WRITE) begin
            wr_addr_d = idx_q;
            wr_data_d = pack_word;
            idx_d     = idx_q + 1'b1;
            rem_d     = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= '0;
            rem_q     <= '0;
            error_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            error_q   <= error_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Live values during the write strobe, last written values otherwise.
    assign wr_addr = wr_en ? idx_q     : wr_addr_q;
    assign wr_data = wr_en ? pack_word : wr_data_q;
    assign error   = error_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_acc) begin
            csum_d = '0;
        end else if (wr_en) begin
            csum_d = csum_q + wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are driven.
module tb_imem_loader;
    import imem_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [WORD_W-1:0] checksum;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned done_cnt = 0;
    logic [WORD_W-1:0] csum_model;
    logic [ADDR_W+WORD_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (wr_en) begin
                logic [ADDR_W+WORD_W-1:0] e;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_in_write got=%0b want=0", in_ready);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got addr=%0d data=%h want none", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        errors++;
                        $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                                 wr_addr, wr_data, e[ADDR_W+WORD_W-1:WORD_W], e[WORD_W-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    function automatic logic [WORD_W-1:0] exp_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        return csum_model;
`else
        return '0;
`endif
    endfunction

    task automatic start_load(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
        start = 1'b1; base_addr = b; word_count = c;
        csum_model = '0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        bit acc = 0;
        in_byte = b; in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) acc = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL byte_accept got no in_ready want accept of %h", b);
        end
        if (stall) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] w, input bit stall);
        exp_q.push_back({a, w});
        csum_model = csum_model + w;
        for (int unsigned k = 0; k < 4; k++) send_byte(w[8*k +: 8], stall);
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done got no pulse want pulse", name);
        end
        checks++;
        if (checksum !== exp_csum()) begin
            errors++;
            $display("FAIL %s_checksum got %h want %h", name, checksum, exp_csum());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        in_byte = '0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, wr_en, busy, done, error, wr_addr, wr_data, checksum} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%0b we=%0b busy=%0b done=%0b err=%0b a=%0d d=%h cs=%h want all 0",
                     in_ready, wr_en, busy, done, error, wr_addr, wr_data, checksum);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        start_load(7'd0, 8'd1);
        exp_q.push_back({7'd0, 32'h0010_0093});
        csum_model = 32'h0010_0093;
        send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 7'd0, 32'h0010_0093}) begin
            errors++;
            $display("FAIL single_write got we=%0b a=%0d d=%h want we=1 a=0 d=00100093", wr_en, wr_addr, wr_data);
        end
        @(negedge clk);
        checks++;
        if ({done, wr_en, busy} !== 3'b100) begin
            errors++;
            $display("FAIL single_done_latency got done=%0b we=%0b busy=%0b want 1 0 0", done, wr_en, busy);
        end
        checks++;
        if (checksum !== exp_csum()) begin
            errors++;
            $display("FAIL single_checksum got %h want %h", checksum, exp_csum());
        end
        @(negedge clk);
        checks++;
        if ({done, wr_addr, wr_data} !== {1'b0, 7'd0, 32'h0010_0093}) begin
            errors++;
            $display("FAIL single_hold got done=%0b a=%0d d=%h want 0 0 00100093", done, wr_addr, wr_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        start_load(7'd5, 8'd3);
        send_word(7'd5, 32'hDEAD_BEEF, 1);
        send_word(7'd6, 32'h0123_4567, 1);
        send_word(7'd7, 32'hA5C3_0F81, 1);
        wait_done("stall");
    endtask

    task automatic test_range();
        int unsigned d0 = done_cnt;
        start_load(7'd120, 8'd9);
        @(negedge clk);
        checks++;
        if ({error, busy} !== 2'b10) begin
            errors++;
            $display("FAIL range_error got err=%0b busy=%0b want 1 0", error, busy);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || error !== 1'b1) begin
            errors++;
            $display("FAIL range_quiet got done_cnt=%0d err=%0b want %0d 1", done_cnt, error, d0);
        end
        start_load(7'd120, 8'd8);
        @(negedge clk);
        checks++;
        if ({error, busy} !== 2'b01) begin
            errors++;
            $display("FAIL range_clear got err=%0b busy=%0b want 0 1", error, busy);
        end
        @(posedge clk); #1;
        for (int unsigned i = 0; i < 8; i++) send_word(7'(120 + i), $urandom, 0);
        wait_done("range_edge");
    endtask

    task automatic test_zero_count();
        start_load(7'd50, 8'd0);
        @(negedge clk);
        checks++;
        if ({done, busy, wr_en} !== 3'b100) begin
            errors++;
            $display("FAIL zero_done got done=%0b busy=%0b we=%0b want 1 0 0", done, busy, wr_en);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse_width got done=%0b want 0", done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midload();
        start_load(7'd10, 8'd2);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, wr_en, busy, done, error, wr_addr, wr_data, checksum} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got rdy=%0b we=%0b busy=%0b done=%0b err=%0b a=%0d d=%h cs=%h want all 0",
                     in_ready, wr_en, busy, done, error, wr_addr, wr_data, checksum);
        end
        @(posedge clk); #1;
        start_load(7'd3, 8'd1);
        send_word(7'd3, 32'h8765_4321, 0);
        wait_done("after_reset");
    endtask

    task automatic test_back_to_back();
        start_load(7'd20, 8'd2);
        exp_q.push_back({7'd20, 32'h0000_00CC});
        csum_model = 32'h0000_00CC;
        send_byte(8'hCC, 0);
        start = 1'b1; base_addr = 7'd0; word_count = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_restart got busy=%0b want 1", busy);
        end
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_word(7'd21, 32'hCAFE_F00D, 0);
        wait_done("no_restart");
        start_load(7'd127, 8'd1);
        send_word(7'd127, 32'h7FFF_FFFF, 0);
        wait_done("top_word");
    endtask

    task automatic test_checksum();
        start_load(7'd40, 8'd3);
        send_word(7'd40, 32'h0000_0001, 0);
        send_word(7'd41, 32'hFFFF_FFFF, 0);
        send_word(7'd42, 32'h0000_0005, 0);
        checks++;
        if (exp_csum() !== `ifdef IMEM_LOADER_CHECKSUM_EN 32'h0000_0005 `else 32'h0 `endif) begin
            errors++;
            $display("FAIL checksum_model got %h want wrapped sum", exp_csum());
        end
        wait_done("checksum");
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_range();
        test_zero_count();
        test_reset_midload();
        test_back_to_back();
        test_checksum();
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_writes got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
